// File: rtl/dds_voice_sched.sv
// dds_voice_sched: four-voice DDS phase scheduler sharing one waveform LUT.
//   On each sample tick the voices are visited in order 0..3. An enabled voice
//   advances its phase accumulator and fetches one LUT sample over a req/ack
//   handshake; a disabled voice keeps its phase and contributes 0. When the
//   frame ends, smp_data is updated and smp_valid pulses for one cycle.
// Latency: smp_valid is high 9 cycles after the tick cycle with all voices
//   enabled and lut_ack tied high, and 5 cycles after it with all voices off.
//   Each extra cycle that lut_ack is held back adds one cycle.
// Backpressure: lut_req/lut_phase stay stable until lut_ack, with no timeout.
//   A tick that arrives while busy is dropped and flagged on overrun.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   tick                                sample-rate strobe; starts a frame
//   cfg_we, cfg_sel, cfg_tune,          per-voice config write, accepted in
//   cfg_ena, cfg_clr                    any state; cfg_clr zeroes the phase
//   lut_req, lut_phase                  LUT request and the phase to look up
//   lut_ack, lut_data                   LUT acknowledge, data valid with ack
//   smp_valid, smp_data                 mixed sample pulse and held value
//   busy, overrun                       frame in progress; dropped tick pulse
//
// Build option: DDS_SCHED_MIX_EN defined   -> smp_data = {sum of 4 samples, 2'b00}
//               DDS_SCHED_MIX_EN undefined -> smp_data = {sample 0, 4'b0000}

module dds_voice_sched #(
  parameter int TUNE_W  = 16,
  parameter int PHASE_W = 14,
  parameter int WAVE_W  = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_sel,
  input  logic [TUNE_W-1:0]  cfg_tune,
  input  logic               cfg_ena,
  input  logic               cfg_clr,
  output logic               lut_req,
  output logic [PHASE_W-1:0] lut_phase,
  input  logic               lut_ack,
  input  logic [WAVE_W-1:0]  lut_data,
  output logic               smp_valid,
  output logic [15:0]        smp_data,
  output logic               busy,
  output logic               overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADV  = 2'd1,
    REQ  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q;
  logic [1:0]          v_q;
  logic [TUNE_W-1:0]   phase_q [4];
  logic [TUNE_W-1:0]   tune_q  [4];
  logic [3:0]          ena_q;
  logic [WAVE_W-1:0]   samp_q  [4];

  logic                lut_req_q;
  logic [PHASE_W-1:0]  lut_phase_q;
  logic                smp_valid_q;
  logic [15:0]         smp_data_q;
  logic                busy_q;
  logic                overrun_q;

  logic [TUNE_W-1:0]   phase_adv_d;
  logic [WAVE_W-1:0]   samp_d [4];
  logic [15:0]         smp_data_d;
  logic                last_voice;

  assign last_voice  = (v_q == 2'd3);
  // The tune register is read only at this voice's ADV step, so a write to a
  // voice that has already been visited lands in the next frame.
  assign phase_adv_d = phase_q[v_q] + tune_q[v_q];

  // Sample array as it will look after this edge. The output mix is taken
  // from it so the final voice's sample (captured on this same edge) counts.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      samp_d[i] = samp_q[i];
    end
    if (state_q == ADV && !ena_q[v_q]) begin
      samp_d[v_q] = '0;
    end
    if (state_q == REQ && lut_ack) begin
      samp_d[v_q] = lut_data;
    end
  end

`ifdef DDS_SCHED_MIX_EN
  // Four WAVE_W-bit samples need exactly two extra bits, so the sum is exact.
  logic [WAVE_W+1:0] sum_d;
  always_comb begin
    sum_d = {2'b00, samp_d[0]} + {2'b00, samp_d[1]}
          + {2'b00, samp_d[2]} + {2'b00, samp_d[3]};
    smp_data_d = 16'({sum_d, 2'b00});
  end
`else
  always_comb begin
    smp_data_d = 16'({samp_d[0], 4'b0000});
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      v_q         <= 2'd0;
      ena_q       <= '0;
      for (int i = 0; i < 4; i++) begin
        phase_q[i] <= '0;
        tune_q[i]  <= '0;
        samp_q[i]  <= '0;
      end
      lut_req_q   <= 1'b0;
      lut_phase_q <= '0;
      smp_valid_q <= 1'b0;
      smp_data_q  <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      smp_valid_q <= 1'b0;
      // A tick during a frame is ignored; the frame carries on untouched.
      overrun_q   <= tick && (state_q != IDLE);
      for (int i = 0; i < 4; i++) begin
        samp_q[i] <= samp_d[i];
      end

      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q <= ADV;
            v_q     <= 2'd0;
            busy_q  <= 1'b1;
          end
        end
        ADV: begin
          if (ena_q[v_q]) begin
            phase_q[v_q] <= phase_adv_d;
            lut_req_q    <= 1'b1;
            lut_phase_q  <= phase_adv_d[TUNE_W-1 -: PHASE_W];
            state_q      <= REQ;
          end else if (last_voice) begin
            smp_data_q  <= smp_data_d;
            smp_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            v_q <= v_q + 2'd1;
          end
        end
        REQ: begin
          if (lut_ack) begin
            lut_req_q <= 1'b0;
            if (last_voice) begin
              smp_data_q  <= smp_data_d;
              smp_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              v_q     <= v_q + 2'd1;
              state_q <= ADV;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          v_q     <= 2'd0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      // Config writes are accepted in any state. Placed last so a phase clear
      // takes precedence over an advance of the same voice on the same edge.
      if (cfg_we) begin
        tune_q[cfg_sel] <= cfg_tune;
        ena_q[cfg_sel]  <= cfg_ena;
        if (cfg_clr) begin
          phase_q[cfg_sel] <= '0;
        end
      end
    end
  end

  assign lut_req   = lut_req_q;
  assign lut_phase = lut_phase_q;
  assign smp_valid = smp_valid_q;
  assign smp_data  = smp_data_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_dds_voice_sched.sv
// Bench for dds_voice_sched: directed frames with hand-computed LUT phases,
// mixed samples and tick-to-sample latencies, queued per frame and checked by
// a separate monitor whenever the DUT handshakes on the LUT or emits a sample.

module tb_dds_voice_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_tune;
  logic        cfg_ena;
  logic        cfg_clr;
  logic        lut_req;
  logic [13:0] lut_phase;
  logic        lut_ack = 1'b0;
  logic [11:0] lut_data;
  logic        smp_valid;
  logic [15:0] smp_data;
  logic        busy;
  logic        overrun;

  always #5 clk = ~clk;

  dds_voice_sched #(.TUNE_W(16), .PHASE_W(14), .WAVE_W(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_tune  (cfg_tune),
    .cfg_ena   (cfg_ena),
    .cfg_clr   (cfg_clr),
    .lut_req   (lut_req),
    .lut_phase (lut_phase),
    .lut_ack   (lut_ack),
    .lut_data  (lut_data),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .busy      (busy),
    .overrun   (overrun)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_smp    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    int          lat;
    int          tcyc;
  } smp_exp_t;

  smp_exp_t    smp_q[$];
  logic [13:0] lut_q[$];

  // LUT responder: either acks every request at once, or holds the request
  // for ack_delay cycles and acks in the cycle after that.
  bit          ack_tie   = 1'b1;
  int          ack_delay = 0;
  logic [11:0] lut_val   = 12'h000;
  int          wcnt      = 0;

  assign lut_data = lut_val;

  always begin
    @(posedge clk);
    #1;
    if (!rst_n || !lut_req) wcnt = 0;
    else                    wcnt++;
    lut_ack = ack_tie ? 1'b1 : (lut_req && (wcnt > ack_delay));
  end

  // Monitor: pops and compares on every LUT handshake and every sample pulse.
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic        prev_sv  = 1'b0;
  logic [13:0] prev_ph  = '0;
  int          hold     = 0;
  int          exp_hold;
  logic [13:0] exp_ph;
  smp_exp_t    exp_s;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
      prev_sv  = 1'b0;
      hold     = 0;
    end else begin
      if (prev_sv) begin
        checks++;
        if (smp_valid) begin
          failures++;
          $display("FAIL smp_valid_pulse actual=wider than 1 cycle required=1 cycle at cyc %0d", cyc);
        end
      end
      if (prev_req && !prev_ack) begin
        checks++;
        if (!lut_req || lut_phase !== prev_ph) begin
          failures++;
          $display("FAIL lut_hold actual req=%0b phase=%h required req=1 phase=%h", lut_req, lut_phase, prev_ph);
        end
      end
      if (lut_req) hold++;
      else         hold = 0;
      if (lut_req && lut_ack) begin
        checks++;
        if (lut_q.size() == 0) begin
          failures++;
          $display("FAIL lut_phase actual=unexpected handshake phase=%h required=none", lut_phase);
        end else begin
          exp_ph = lut_q.pop_front();
          if (lut_phase !== exp_ph) begin
            failures++;
            $display("FAIL lut_phase actual=%h required=%h", lut_phase, exp_ph);
          end
        end
        checks++;
        exp_hold = ack_tie ? 1 : ack_delay + 1;
        if (hold != exp_hold) begin
          failures++;
          $display("FAIL lut_req_cycles actual=%0d required=%0d", hold, exp_hold);
        end
        hold = 0;
      end
      if (smp_valid) begin
        n_smp++;
        checks++;
        if (smp_q.size() == 0) begin
          failures++;
          $display("FAIL smp_valid actual=unexpected pulse data=%h required=no pulse", smp_data);
        end else begin
          exp_s = smp_q.pop_front();
          if (smp_data !== exp_s.data) begin
            failures++;
            $display("FAIL smp_data actual=%h required=%h", smp_data, exp_s.data);
          end
          checks++;
          if (cyc - exp_s.tcyc != exp_s.lat) begin
            failures++;
            $display("FAIL smp_latency actual=%0d required=%0d", cyc - exp_s.tcyc, exp_s.lat);
          end
        end
      end
      prev_req = lut_req;
      prev_ack = lut_ack;
      prev_ph  = lut_phase;
      prev_sv  = smp_valid;
    end
  end

  // Expected smp_data for the build in use: mixed or voice-0-only.
  function automatic logic [15:0] sd(input logic [15:0] mix_v, input logic [15:0] solo_v);
`ifdef DDS_SCHED_MIX_EN
    return mix_v;
`else
    return solo_v;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] s, input logic [15:0] t, input logic e, input logic c);
    cfg_we   = 1'b1;
    cfg_sel  = s;
    cfg_tune = t;
    cfg_ena  = e;
    cfg_clr  = c;
    step();
    cfg_we   = 1'b0;
    cfg_clr  = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic start_frame(input logic [15:0] data, input int lat);
    smp_exp_t e;
    e.data = data;
    e.lat  = lat;
    e.tcyc = cyc;
    smp_q.push_back(e);
    pulse_tick();
  endtask

  task automatic wait_smp(input int target);
    int b = 0;
    while (n_smp < target && b < 200) begin
      step();
      b++;
    end
    checks++;
    if (n_smp < target) begin
      failures++;
      $display("FAIL smp_timeout actual=%0d samples required=%0d", n_smp, target);
    end
  endtask

  task automatic frame(input logic [15:0] data, input int lat);
    int tgt;
    tgt = n_smp + 1;
    start_frame(data, lat);
    wait_smp(tgt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    rst_n    = 1'b0;
    tick     = 1'b0;
    cfg_we   = 1'b0;
    cfg_sel  = 2'd0;
    cfg_tune = 16'h0000;
    cfg_ena  = 1'b0;
    cfg_clr  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lut_req",   {31'd0, lut_req},   32'd0);
    chk("rst_lut_phase", {18'd0, lut_phase}, 32'd0);
    chk("rst_smp_valid", {31'd0, smp_valid}, 32'd0);
    chk("rst_smp_data",  {16'd0, smp_data},  32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_overrun",   {31'd0, overrun},   32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Voice 0 tune 0x0100, others tune 0, all enabled, ack tied high.
    lut_val = 12'hABC;
    cfg(2'd0, 16'h0100, 1'b1, 1'b1);
    cfg(2'd1, 16'h0000, 1'b1, 1'b1);
    cfg(2'd2, 16'h0000, 1'b1, 1'b1);
    cfg(2'd3, 16'h0000, 1'b1, 1'b1);
    lut_q.push_back(14'h0040); lut_q.push_back(14'h0000); lut_q.push_back(14'h0000); lut_q.push_back(14'h0000);
    frame(sd(16'hABC0, 16'hABC0), 9);
    lut_q.push_back(14'h0080); lut_q.push_back(14'h0000); lut_q.push_back(14'h0000); lut_q.push_back(14'h0000);
    frame(sd(16'hABC0, 16'hABC0), 9);
    lut_q.push_back(14'h00C0); lut_q.push_back(14'h0000); lut_q.push_back(14'h0000); lut_q.push_back(14'h0000);
    frame(sd(16'hABC0, 16'hABC0), 9);

    // Phase wrap: 0xFFFF, 0xFFFE; then +5 lands on 0x0003.
    lut_val = 12'hFFF;
    cfg(2'd0, 16'hFFFF, 1'b1, 1'b1);
    lut_q.push_back(14'h3FFF); lut_q.push_back(14'h0000); lut_q.push_back(14'h0000); lut_q.push_back(14'h0000);
    frame(16'hFFF0, 9);
    lut_q.push_back(14'h3FFF); lut_q.push_back(14'h0000); lut_q.push_back(14'h0000); lut_q.push_back(14'h0000);
    frame(16'hFFF0, 9);
    cfg(2'd0, 16'h0005, 1'b1, 1'b0);
    lut_q.push_back(14'h0000); lut_q.push_back(14'h0000); lut_q.push_back(14'h0000); lut_q.push_back(14'h0000);
    frame(16'hFFF0, 9);

    // Voice 0 off, voices 1-3 on: 3 * 0x123 mixed, or 0 from voice 0 alone.
    lut_val = 12'h123;
    cfg(2'd0, 16'h0000, 1'b0, 1'b0);
    cfg(2'd1, 16'h1000, 1'b1, 1'b1);
    cfg(2'd2, 16'h2000, 1'b1, 1'b1);
    cfg(2'd3, 16'h0000, 1'b1, 1'b1);
    lut_q.push_back(14'h0400); lut_q.push_back(14'h0800); lut_q.push_back(14'h0000);
    frame(sd(16'h0DA4, 16'h0000), 8);

    // All voices off.
    cfg(2'd1, 16'h1000, 1'b0, 1'b0);
    cfg(2'd2, 16'h2000, 1'b0, 1'b0);
    cfg(2'd3, 16'h0000, 1'b0, 1'b0);
    frame(16'h0000, 5);

    // Delayed ack (5 cycles) with a tick dropped mid-frame.
    ack_tie   = 1'b0;
    ack_delay = 5;
    lut_val   = 12'h456;
    cfg(2'd0, 16'h0100, 1'b1, 1'b1);
    lut_q.push_back(14'h0040);
    saved = n_smp + 1;
    start_frame(sd(16'h1158, 16'h4560), 11);
    step();
    step();
    pulse_tick();
    @(negedge clk);
    chk("overrun_pulse", {31'd0, overrun}, 32'd1);
    chk("busy_in_frame", {31'd0, busy},    32'd1);
    @(negedge clk);
    chk("overrun_clear", {31'd0, overrun}, 32'd0);
    wait_smp(saved);

    // Voices 0 and 2; clear voice 2 and retune voice 0 mid-frame.
    cfg(2'd2, 16'h0800, 1'b1, 1'b0);
    lut_q.push_back(14'h0080); lut_q.push_back(14'h0A00);
    frame(sd(16'h22B0, 16'h4560), 17);
    lut_q.push_back(14'h00C0); lut_q.push_back(14'h0200);
    saved = n_smp + 1;
    start_frame(sd(16'h22B0, 16'h4560), 17);
    step();
    cfg(2'd2, 16'h0800, 1'b1, 1'b1);
    cfg(2'd0, 16'h1000, 1'b1, 1'b0);
    wait_smp(saved);
    lut_q.push_back(14'h04C0); lut_q.push_back(14'h0400);
    frame(sd(16'h22B0, 16'h4560), 17);

    // Reset while waiting in REQ: frame aborted, phases cleared.
    ack_delay = 20;
    saved = n_smp;
    pulse_tick();
    step();
    chk("req_before_rst",   {31'd0, lut_req},   32'd1);
    chk("phase_before_rst", {18'd0, lut_phase}, 32'h08C0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_lut_req",   {31'd0, lut_req},   32'd0);
    chk("rst_mid_busy",      {31'd0, busy},      32'd0);
    chk("rst_mid_lut_phase", {18'd0, lut_phase}, 32'd0);
    step();
    step();
    rst_n   = 1'b1;
    ack_tie = 1'b1;
    repeat (20) step();
    chk("no_smp_after_abort", n_smp, saved);
    cfg(2'd0, 16'h0400, 1'b1, 1'b0);
    cfg(2'd1, 16'h0040, 1'b1, 1'b0);
    cfg(2'd2, 16'h0100, 1'b1, 1'b0);
    cfg(2'd3, 16'hFFFC, 1'b1, 1'b0);
    lut_val = 12'h0AA;
    lut_q.push_back(14'h0100); lut_q.push_back(14'h0010); lut_q.push_back(14'h0040); lut_q.push_back(14'h3FFF);
    frame(16'h0AA0, 9);

    repeat (3) step();
    chk("lut_queue_drained", lut_q.size(), 0);
    chk("smp_queue_drained", smp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
